// File: rtl/impulse_env_pkg.sv
// Shared types and constants for the Impulse ADSR envelope generator.
// The optional exponential decay/release curve is selected by ENV_EXP_RELEASE_EN.
package impulse_env_pkg;

   localparam int LEVEL_W = 24;
   localparam int FRAC_W  = 8;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 24'h7FFF00;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

endpackage

// File: rtl/env_level_step.sv
// Combinational level ramp: saturating add up to a ceiling, or subtract down to a floor.
// reached flags that the bound was hit and the result was clamped to it.
module env_level_step #(
   parameter int W = 24
) (
   input  logic [W-1:0] level,
   input  logic [W-1:0] step,
   input  logic [W-1:0] bound,
   input  logic         up,
   output logic [W-1:0] next_level,
   output logic         reached
);

   logic [W:0] sum;
   logic [W:0] lim;

   always_comb begin
      // One extra bit so neither the sum nor the floor comparison can wrap.
      sum        = {1'b0, level} + {1'b0, step};
      lim        = {1'b0, bound} + {1'b0, step};
      next_level = level;
      reached    = 1'b0;
      if (up) begin
         if (sum >= {1'b0, bound}) begin
            next_level = bound;
            reached    = 1'b1;
         end else begin
            next_level = sum[W-1:0];
         end
      end else begin
         if ({1'b0, level} <= lim) begin
            next_level = bound;
            reached    = 1'b1;
         end else begin
            next_level = level - step;
         end
      end
   end

endmodule

// File: rtl/env_adsr.sv
// Gate-driven ADSR envelope; updates once per tick and outputs a non-negative 17-bit volume.
// Define ENV_EXP_RELEASE_EN for exponential decay/release steps of (level >> rate[3:0]) + 1.
module env_adsr #(
   parameter int LEVEL_W = impulse_env_pkg::LEVEL_W,
   parameter int FRAC_W  = impulse_env_pkg::FRAC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               gate,
   input  logic [15:0]        attack_rate,
   input  logic [15:0]        decay_rate,
   input  logic [14:0]        sustain_level,
   input  logic [15:0]        release_rate,
   output logic signed [16:0] volume,
   output logic [2:0]         state,
   output logic               active
);

   import impulse_env_pkg::*;

   localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(32767) << FRAC_W;

   env_state_t         st, st_nxt;
   logic [LEVEL_W-1:0] level, level_nxt;
   logic               gate_q, armed;
   logic               rise;
   logic [LEVEL_W-1:0] target;
   logic [LEVEL_W-1:0] step_amt, step_bound, step_next;
   logic               step_up, step_hit;

   // armed stays low until gate is seen low after reset, so a gate held
   // through reset cannot start a note.
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         level  <= '0;
         gate_q <= 1'b0;
         armed  <= 1'b0;
      end else if (tick) begin
         st     <= st_nxt;
         level  <= level_nxt;
         gate_q <= gate;
         if (!gate) armed <= 1'b1;
      end
   end

   assign target = LEVEL_W'(sustain_level) << FRAC_W;
   assign rise   = gate & ~gate_q & armed;

   env_level_step #(.W(LEVEL_W)) u_step (
      .level      (level),
      .step       (step_amt),
      .bound      (step_bound),
      .up         (step_up),
      .next_level (step_next),
      .reached    (step_hit)
   );

   always_comb begin
      step_up    = (st == ATTACK);
      step_bound = LVL_MAX;
      step_amt   = LEVEL_W'(attack_rate);
      if (st == DECAY) begin
         step_bound = target;
`ifdef ENV_EXP_RELEASE_EN
         step_amt   = (level >> decay_rate[3:0]) + LEVEL_W'(1);
`else
         step_amt   = LEVEL_W'(decay_rate);
`endif
      end else if (st == RELEASE) begin
         step_bound = '0;
`ifdef ENV_EXP_RELEASE_EN
         step_amt   = (level >> release_rate[3:0]) + LEVEL_W'(1);
`else
         step_amt   = LEVEL_W'(release_rate);
`endif
      end

      st_nxt    = st;
      level_nxt = level;
      if (rise) begin
         st_nxt = ATTACK;
      end else begin
         case (st)
            IDLE: ;
            ATTACK, DECAY: begin
               if (!gate) begin
                  st_nxt = RELEASE;
               end else begin
                  level_nxt = step_next;
                  if (step_hit) st_nxt = (st == ATTACK) ? DECAY : SUSTAIN;
               end
            end
            SUSTAIN: begin
               if (!gate) st_nxt = RELEASE;
               else       level_nxt = target;
            end
            RELEASE: begin
               level_nxt = step_next;
               if (step_hit) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      volume = {2'b00, level[FRAC_W+14:FRAC_W]};
      state  = st;
      active = (st != IDLE);
   end

endmodule

// File: tb/tb_env_adsr.sv
// Directed bench for env_adsr: hand-computed volume/state/active after each tick burst.
// Define ENV_EXP_RELEASE_EN to exercise the exponential release instead of the linear scenarios.
module tb_env_adsr;

   logic               clk = 1'b0;
   logic               rst;
   logic               tick;
   logic               gate;
   logic [15:0]        attack_rate;
   logic [15:0]        decay_rate;
   logic [14:0]        sustain_level;
   logic [15:0]        release_rate;
   logic signed [16:0] volume;
   logic [2:0]         state;
   logic               active;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   env_adsr dut (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .gate          (gate),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .volume        (volume),
      .state         (state),
      .active        (active)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge clk);
      end
      tick = 1'b0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int v, input int s, input int a);
      check({tag, "_vol"}, 32'(volume), v);
      check({tag, "_state"}, 32'(state), s);
      check({tag, "_active"}, 32'(active), a);
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; gate = 1'b1;
      attack_rate = 16'h8000; decay_rate = 16'h1000;
      sustain_level = 15'd16384; release_rate = 16'h4000;

      // Reset with tick and gate high; held gate must not trigger afterwards
      tick = 1'b1;
      repeat (3) @(negedge clk);
      tick = 1'b0;
      check_all("reset", 0, 0, 0);
      rst = 1'b0;
      tick_n(3);
      check_all("held_gate", 0, 0, 0);
      gate = 1'b0;
      tick_n(1);
      check_all("arm", 0, 0, 0);

`ifdef ENV_EXP_RELEASE_EN
      begin
         int cnt;
         int prev;
         sustain_level = 15'd32767; decay_rate = 16'h0000;
         gate = 1'b1;
         tick_n(1);
         check_all("x_rise", 0, 1, 1);
         tick_n(256);
         check_all("x_atk_top", 32767, 2, 1);
         tick_n(1);
         check_all("x_sus", 32767, 3, 1);
         release_rate = 16'h0004;
         gate = 1'b0;
         tick_n(1);
         check_all("x_rel_enter", 32767, 4, 1);
         tick_n(1);
         check_all("x_rel_first", 30719, 4, 1);
         prev = 30719;
         cnt  = 0;
         while (state != 3'd0 && cnt < 400) begin
            tick_n(1);
            check("x_mono", 32'(int'(volume) <= prev), 1);
            prev = int'(volume);
            cnt++;
         end
         check_all("x_done", 0, 0, 0);
      end
`else
      // Zero attack rate holds in ATTACK; reset mid-note drops to 0
      attack_rate = 16'h0000;
      gate = 1'b1;
      tick_n(1);
      check_all("zero_atk_rise", 0, 1, 1);
      tick_n(5);
      check_all("zero_atk_hold", 0, 1, 1);
      attack_rate = 16'h8000;
      tick_n(3);
      check_all("atk3", 384, 1, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all("mid_reset", 0, 0, 0);
      gate = 1'b0;
      tick_n(1);

      // Full note, with tick gating inside the attack
      gate = 1'b1;
      tick_n(1);
      check_all("note_rise", 0, 1, 1);
      tick_n(100);
      check_all("atk100", 12800, 1, 1);
      repeat (100) @(negedge clk);
      check_all("tick_hold", 12800, 1, 1);
      for (int k = 1; k <= 4; k++) begin
         tick_n(1);
         check("sparse_tick_vol", 32'(volume), 32'(12800 + 128 * k));
         repeat (3) @(negedge clk);
         check("sparse_idle_vol", 32'(volume), 32'(12800 + 128 * k));
      end
      tick_n(151);
      check_all("atk255", 32640, 1, 1);
      tick_n(1);
      check_all("atk_top", 32767, 2, 1);
      tick_n(1023);
      check_all("dec1023", 16399, 2, 1);
      tick_n(1);
      check_all("dec_done", 16384, 3, 1);
      sustain_level = 15'd10000;
      tick_n(1);
      check_all("sus_track", 10000, 3, 1);
      sustain_level = 15'd16384;
      tick_n(1);
      check_all("sus_back", 16384, 3, 1);
      gate = 1'b0;
      tick_n(1);
      check_all("rel_enter", 16384, 4, 1);
      tick_n(255);
      check_all("rel255", 64, 4, 1);
      tick_n(1);
      check_all("rel_done", 0, 0, 0);

      // Retrigger from release at 20000
      decay_rate = 16'hFFFF; sustain_level = 15'd20000;
      gate = 1'b1;
      tick_n(1);
      tick_n(256);
      check_all("rt_top", 32767, 2, 1);
      tick_n(60);
      check_all("rt_sus", 20000, 3, 1);
      gate = 1'b0;
      tick_n(1);
      check_all("rt_rel", 20000, 4, 1);
      tick_n(10);
      check_all("rt_rel10", 19360, 4, 1);
      gate = 1'b1;
      tick_n(1);
      check_all("rt_rise", 19360, 1, 1);
      tick_n(1);
      check_all("rt_atk", 19488, 1, 1);

      // Sustain at full scale: DECAY ends on its first tick
      sustain_level = 15'd32767;
      tick_n(103);
      check_all("smax_atk", 32672, 1, 1);
      tick_n(1);
      check_all("smax_top", 32767, 2, 1);
      tick_n(1);
      check_all("smax_sus", 32767, 3, 1);

      // Sustain at zero keeps the note active
      sustain_level = 15'd0;
      tick_n(1);
      check_all("szero", 0, 3, 1);

      // Release rate larger than the level: one tick to IDLE, no underflow
      sustain_level = 15'd1;
      tick_n(1);
      check_all("s1", 1, 3, 1);
      release_rate = 16'hFFFF;
      gate = 1'b0;
      tick_n(1);
      check_all("big_rel_enter", 1, 4, 1);
      tick_n(1);
      check_all("big_rel_done", 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/env_adsr.md
Name: env_adsr

Overview:
- ADSR envelope generator that produces the signed 17-bit `volume` word consumed by the Impulse oscillators (noise, square, etc.); sits directly upstream of each oscillator's volume input.
- Gate-driven state machine advances a fixed-point level once per sample tick.
- Output is always non-negative, in 0..32767.

Parameters:
- LEVEL_W, 24, internal level accumulator width (15 integer bits + FRAC_W fraction, 1 headroom bit)
- FRAC_W, 8, fractional bits of the level accumulator

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle sample-rate strobe; all envelope updates occur only on cycles with tick=1
- gate  in  1  note on (1) / note off (0)
- attack_rate  in  16  level increment per tick in ATTACK (units of 2^-FRAC_W)
- decay_rate  in  16  level decrement per tick in DECAY
- sustain_level  in  15  sustain target, 0..32767
- release_rate  in  16  level decrement per tick in RELEASE
- volume  out  17 signed  envelope output, {2'b00, level[22:8]}
- state  out  3  current state encoding (debug/observe)
- active  out  1  1 whenever state != IDLE

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst (synchronous, active-high) forces level=0, state=IDLE, gate_q=0, volume=0, active=0, regardless of tick. A reset mid-note drops the output to 0 on the next edge.
- Constants:
  - LEVEL_MAX = 32767<<8 = 0x7FFF00.
  - Target = sustain_level<<8.
- Gate sampling:
  - gate_q is updated only on tick cycles.
  - rise = gate & ~gate_q; gate is sampled only on tick cycles.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. All evaluation happens on tick cycles; with tick=0, all registers hold.
- Transitions and arithmetic:
  - rise, in any state: enter ATTACK with level unchanged (retrigger from the current level, no click). rise takes priority over all other transitions in that tick.
  - ATTACK: level = min(level + attack_rate, LEVEL_MAX). When the result equals LEVEL_MAX, go to DECAY.
  - DECAY: if level - decay_rate <= target, then level = target and go to SUSTAIN; otherwise subtract.
    - Compare in LEVEL_W+1 bits, so there is no wrap.
    - If target >= level on entry, clamp to target immediately.
  - SUSTAIN: level = target. It tracks live changes of sustain_level.
  - RELEASE: if level <= release_rate, then level = 0 and go to IDLE; otherwise subtract.
  - gate=0 (no rise) in ATTACK, DECAY or SUSTAIN: go to RELEASE on that tick; the level is not stepped that tick.
  - IDLE with gate=1 and no rise (gate held high through reset): stay in IDLE.
- Zero rates:
  - A rate of 0 holds the level in that state indefinitely, except for gate-driven exits.
  - attack_rate=0 with level<LEVEL_MAX holds in ATTACK.
- Latency: volume, state and active are registered and reflect the tick on the following edge, i.e. 1 cycle after the tick cycle.
- Saturation: arithmetic is unsigned with explicit saturation; level never exceeds LEVEL_MAX and never underflows.

Optional Feature:
- ENV_EXP_RELEASE_EN
  - Defined: in DECAY and RELEASE, step = (level >> rate[3:0]) + 1 instead of rate (exponential curve); rate[15:4] is ignored. The termination and clamp rules are unchanged.
  - Undefined: linear steps exactly as described in Behaviour.

Decomposition:
- Package impulse_env_pkg holds:
  - env_state_t enum (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4)
  - LEVEL_W, FRAC_W, LEVEL_MAX
- Sub-module env_level_step: combinational saturating add/sub-with-floor.
  - Inputs: level, step, floor/ceiling, direction.
  - Outputs: next level and a "reached" flag.
  - Used for all three ramp states.

Test Plan:
- Reset: rst=1 for 3 cycles with gate=1 and tick every cycle -> volume=0, state=IDLE, active=0; after release, the held-high gate does not trigger.
- Full note: attack_rate=0x8000, decay_rate=0x1000, sustain_level=16384, release_rate=0x4000; gate rises -> ATTACK for 256 ticks, volume=32767; then DECAY for 1024 ticks to volume=16384 (SUSTAIN); gate low -> 256 ticks to volume=0, IDLE.
- Tick gating: tick held at 0 for 100 cycles mid-ATTACK -> volume unchanged; tick every 4th cycle -> updates only 1 cycle after each tick.
- Retrigger: gate drops at volume=20000 and rises again 10 ticks later -> ATTACK resumes from the current level (volume = 20000 - 10×64 = 19360), with no drop to 0.
- Boundaries:
  - sustain_level=32767 -> DECAY ends on its first tick.
  - sustain_level=0 -> SUSTAIN at volume 0 with active=1.
  - release_rate=0xFFFF at level 0x000100 -> level 0 and IDLE in 1 tick, no underflow.
- ENV_EXP_RELEASE_EN: release_rate[3:0]=4 from volume 32767 -> each step = level/16 + 1, monotonic decrease, reaches 0/IDLE (bench checks termination within 400 ticks).
